// File: rtl/serout_shift_param.sv
// rtl/serout_shift_param.sv - parametrised double-buffered serial output transmitter
module serout_shift_param #(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1,
  parameter int PARITY    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] D,
  input  logic              wr,
  input  logic              shift,
  input  logic              brk,
  output logic              serout,
  output logic              hold_empty,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int PAR_W = (PARITY != 0) ? 1 : 0;
  localparam int FRAME = 1 + DATA_W + PAR_W + STOP_BITS;
  localparam int SR_W  = FRAME - 1;
  localparam int CNT_W = $clog2(FRAME + 1);

  logic [DATA_W-1:0] hold_reg;
  logic [SR_W-1:0]   sr;
  logic [SR_W-1:0]   load_vec;
  logic [CNT_W-1:0]  cnt;
  logic              line;
  logic              line_next;
  logic              par_bit;
  logic              load;
  logic              shift_act;

  assign load      = !busy && !hold_empty;
  assign shift_act = shift && busy;
  assign par_bit   = (^hold_reg) ^ (PARITY == 2);

  // Start bit is emitted at load time, so the shifter holds data, parity and stop bits only.
  always_comb begin
    load_vec = '1;
    load_vec[DATA_W-1:0] = hold_reg;
    if (PARITY != 0) load_vec[DATA_W] = par_bit;
  end

  // Frame bit currently on the line, independent of break.
  always_comb begin
    line_next = line;
    if (load)
      line_next = 1'b0;
    else if (shift_act)
      line_next = (cnt == CNT_W'(1)) ? 1'b1 : sr[0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_reg   <= '0;
      sr         <= '1;
      cnt        <= '0;
      line       <= 1'b1;
      serout     <= 1'b1;
      hold_empty <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else if (en) begin
      done   <= 1'b0;
      line   <= line_next;
      serout <= brk ? 1'b0 : line_next;
      if (load) begin
        sr   <= load_vec;
        cnt  <= CNT_W'(FRAME);
        busy <= 1'b1;
      end else if (shift_act) begin
        if (cnt == CNT_W'(1)) begin
          cnt  <= '0;
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          sr  <= {1'b1, sr[SR_W-1:1]};
          cnt <= cnt - CNT_W'(1);
        end
      end
      // A write coincident with a load refills the buffer the load just drained.
      if (wr) begin
        hold_reg   <= D;
        hold_empty <= 1'b0;
        if (hold_empty)
          overrun <= 1'b0;
        else if (!load)
          overrun <= 1'b1;
      end else if (load) begin
        hold_empty <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serout_shift_param.sv
// tb/tb_serout_shift_param.sv - scoreboard bench for serout_shift_param
module tb_serout_shift_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       wr = 1'b0;
  logic       shift = 1'b0;
  logic       brk = 1'b0;
  logic [8:0] din = '0;
  logic       serout8, hold_empty8, busy8, done8, overrun8;
  logic       serout7, hold_empty7, busy7, done7, overrun7;

  int   checks = 0;
  int   failures = 0;
  int   done_cnt8 = 0;
  int   done_cnt7 = 0;
  bit   sel7 = 1'b0;
  logic exp_q[$];

  always #5 clk = ~clk;

  serout_shift_param #(.DATA_W(8), .STOP_BITS(1), .PARITY(0)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .D(din[7:0]), .wr(wr), .shift(shift), .brk(brk),
    .serout(serout8), .hold_empty(hold_empty8), .busy(busy8), .done(done8), .overrun(overrun8)
  );

  serout_shift_param #(.DATA_W(7), .STOP_BITS(2), .PARITY(2)) u_dut7 (
    .clk(clk), .rst_n(rst_n), .en(en), .D(din[6:0]), .wr(wr), .shift(shift), .brk(brk),
    .serout(serout7), .hold_empty(hold_empty7), .busy(busy7), .done(done7), .overrun(overrun7)
  );

  always @(negedge clk) begin
    if (done8 === 1'b1) done_cnt8++;
    if (done7 === 1'b1) done_cnt7++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic cur_serout();
    return sel7 ? serout7 : serout8;
  endfunction

  function automatic void push_frame(input logic [8:0] dv, input int dw, input int par, input int sb);
    logic p;
    p = 1'b0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < dw; i++) begin
      exp_q.push_back(dv[i]);
      p ^= dv[i];
    end
    if (par != 0) exp_q.push_back(par == 2 ? ~p : p);
    for (int i = 0; i < sb; i++) exp_q.push_back(1'b1);
  endfunction

  // One bit period: a tick cycle (line sampled just before the tick) then a quiet cycle.
  task automatic tick_once(input bit do_wr, input logic [8:0] dv, input bit brk_nxt, input bit brk_exp);
    logic e;
    shift = 1'b1;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL tick_underflow: serout=%b but no expected bit queued", cur_serout());
    end else begin
      e = exp_q.pop_front();
      if (brk_exp) e = 1'b0;
      if (cur_serout() !== e) begin
        failures++;
        $display("FAIL serout_bit: got %b expected %b at %0t", cur_serout(), e, $time);
      end
    end
    step();
    shift = 1'b0;
    brk = brk_nxt;
    if (do_wr) begin
      wr = 1'b1;
      din = dv;
    end
    step();
    wr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b1; wr = 1'b0; shift = 1'b0; brk = 1'b0;
    step();
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic do_write(input logic [8:0] dv);
    wr = 1'b1;
    din = dv;
    step();
    wr = 1'b0;
  endtask

  task automatic test_reset();
    sel7 = 1'b0;
    do_reset();
    checks++; if (serout8 !== 1'b1)     begin failures++; $display("FAIL reset_serout: got %b expected 1", serout8); end
    checks++; if (hold_empty8 !== 1'b1) begin failures++; $display("FAIL reset_hold_empty: got %b expected 1", hold_empty8); end
    checks++; if (busy8 !== 1'b0)       begin failures++; $display("FAIL reset_busy: got %b expected 0", busy8); end
    checks++; if (done8 !== 1'b0)       begin failures++; $display("FAIL reset_done: got %b expected 0", done8); end
    checks++; if (overrun8 !== 1'b0)    begin failures++; $display("FAIL reset_overrun: got %b expected 0", overrun8); end
  endtask

  task automatic test_basic_frame();
    int base;
    sel7 = 1'b0;
    do_reset();
    base = done_cnt8;
    do_write(9'h35);
    checks++; if (hold_empty8 !== 1'b0) begin failures++; $display("FAIL basic_hold_full: got %b expected 0", hold_empty8); end
    checks++; if (busy8 !== 1'b0)       begin failures++; $display("FAIL basic_not_yet_busy: got %b expected 0", busy8); end
    step();
    checks++; if (busy8 !== 1'b1 || hold_empty8 !== 1'b1)
      begin failures++; $display("FAIL basic_load: busy=%b hold_empty=%b expected 1 1", busy8, hold_empty8); end
    push_frame(9'h35, 8, 0, 1);
    for (int i = 0; i < 10; i++) tick_once(1'b0, '0, 1'b0, 1'b0);
    checks++; if (serout8 !== 1'b1 || busy8 !== 1'b0)
      begin failures++; $display("FAIL basic_idle: serout=%b busy=%b expected 1 0", serout8, busy8); end
    checks++; if (done_cnt8 - base !== 1)
      begin failures++; $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt8 - base); end
  endtask

  task automatic test_parity_stop();
    int base;
    sel7 = 1'b1;
    do_reset();
    base = done_cnt7;
    do_write(9'h41);
    step();
    push_frame(9'h41, 7, 2, 2);
    for (int i = 0; i < 11; i++) begin
      if (i == 10) begin
        checks++; if (busy7 !== 1'b1) begin failures++; $display("FAIL parity_busy_last: got %b expected 1", busy7); end
      end
      tick_once(1'b0, '0, 1'b0, 1'b0);
    end
    checks++; if (busy7 !== 1'b0 || serout7 !== 1'b1)
      begin failures++; $display("FAIL parity_idle: busy=%b serout=%b expected 0 1", busy7, serout7); end
    checks++; if (done_cnt7 - base !== 1)
      begin failures++; $display("FAIL parity_done_pulses: got %0d expected 1", done_cnt7 - base); end
    sel7 = 1'b0;
  endtask

  task automatic test_back_to_back();
    int base;
    sel7 = 1'b0;
    do_reset();
    base = done_cnt8;
    do_write(9'h12);
    step();
    push_frame(9'h12, 8, 0, 1);
    push_frame(9'h34, 8, 0, 1);
    for (int i = 0; i < 20; i++) begin
      if (i == 9) begin
        checks++; if (hold_empty8 !== 1'b0) begin failures++; $display("FAIL b2b_pending: got %b expected 0", hold_empty8); end
      end
      if (i == 10) begin
        checks++; if (hold_empty8 !== 1'b1) begin failures++; $display("FAIL b2b_second_load: got %b expected 1", hold_empty8); end
      end
      tick_once(i == 1, 9'h34, 1'b0, 1'b0);
    end
    checks++; if (overrun8 !== 1'b0) begin failures++; $display("FAIL b2b_overrun: got %b expected 0", overrun8); end
    checks++; if (done_cnt8 - base !== 2)
      begin failures++; $display("FAIL b2b_done_pulses: got %0d expected 2", done_cnt8 - base); end
  endtask

  task automatic test_overrun();
    int base;
    sel7 = 1'b0;
    do_reset();
    base = done_cnt8;
    do_write(9'h11);
    step();
    push_frame(9'h11, 8, 0, 1);
    push_frame(9'h33, 8, 0, 1);
    for (int i = 0; i < 20; i++) begin
      if (i == 1) begin
        checks++; if (overrun8 !== 1'b0) begin failures++; $display("FAIL ovr_first_write: got %b expected 0", overrun8); end
      end
      if (i == 2) begin
        checks++; if (overrun8 !== 1'b1) begin failures++; $display("FAIL ovr_set: got %b expected 1", overrun8); end
      end
      tick_once(i <= 1, (i == 0) ? 9'h22 : 9'h33, 1'b0, 1'b0);
    end
    checks++; if (overrun8 !== 1'b1) begin failures++; $display("FAIL ovr_sticky: got %b expected 1", overrun8); end
    checks++; if (done_cnt8 - base !== 2)
      begin failures++; $display("FAIL ovr_done_pulses: got %0d expected 2", done_cnt8 - base); end
    do_write(9'h55);
    checks++; if (overrun8 !== 1'b0) begin failures++; $display("FAIL ovr_clear: got %b expected 0", overrun8); end
  endtask

  task automatic test_write_load();
    int base;
    sel7 = 1'b0;
    do_reset();
    base = done_cnt8;
    do_write(9'h5A);
    do_write(9'h3C);
    checks++; if (busy8 !== 1'b1 || serout8 !== 1'b0)
      begin failures++; $display("FAIL wl_load: busy=%b serout=%b expected 1 0", busy8, serout8); end
    checks++; if (hold_empty8 !== 1'b0 || overrun8 !== 1'b0)
      begin failures++; $display("FAIL wl_queue: hold_empty=%b overrun=%b expected 0 0", hold_empty8, overrun8); end
    push_frame(9'h5A, 8, 0, 1);
    push_frame(9'h3C, 8, 0, 1);
    for (int i = 0; i < 20; i++) tick_once(1'b0, '0, 1'b0, 1'b0);
    checks++; if (done_cnt8 - base !== 2)
      begin failures++; $display("FAIL wl_done_pulses: got %0d expected 2", done_cnt8 - base); end
  endtask

  task automatic test_break();
    int base;
    sel7 = 1'b0;
    do_reset();
    base = done_cnt8;
    do_write(9'hA5);
    step();
    push_frame(9'hA5, 8, 0, 1);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        checks++; if (busy8 !== 1'b1) begin failures++; $display("FAIL brk_busy: got %b expected 1", busy8); end
      end
      tick_once(1'b0, '0, (i >= 2 && i <= 4), (i >= 3 && i <= 5));
    end
    checks++; if (serout8 !== 1'b1 || busy8 !== 1'b0)
      begin failures++; $display("FAIL brk_idle: serout=%b busy=%b expected 1 0", serout8, busy8); end
    checks++; if (done_cnt8 - base !== 1)
      begin failures++; $display("FAIL brk_done_pulses: got %0d expected 1", done_cnt8 - base); end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    sel7 = 1'b0;
    do_reset();
    do_write(9'hA5);
    step();
    push_frame(9'hA5, 8, 0, 1);
    for (int i = 0; i < 4; i++) tick_once(i <= 1, (i == 0) ? 9'h11 : 9'h22, 1'b0, 1'b0);
    checks++; if (overrun8 !== 1'b1) begin failures++; $display("FAIL rmf_overrun_pre: got %b expected 1", overrun8); end
    base = done_cnt8;
    rst_n = 1'b0;
    shift = 1'b1;
    step();
    rst_n = 1'b1;
    shift = 1'b0;
    exp_q.delete();
    checks++; if (serout8 !== 1'b1)     begin failures++; $display("FAIL rmf_serout: got %b expected 1", serout8); end
    checks++; if (busy8 !== 1'b0)       begin failures++; $display("FAIL rmf_busy: got %b expected 0", busy8); end
    checks++; if (hold_empty8 !== 1'b1) begin failures++; $display("FAIL rmf_hold_empty: got %b expected 1", hold_empty8); end
    checks++; if (overrun8 !== 1'b0)    begin failures++; $display("FAIL rmf_overrun: got %b expected 0", overrun8); end
    for (int i = 0; i < 12; i++) begin
      shift = 1'b1; step(); shift = 1'b0; step();
      checks++; if (serout8 !== 1'b1) begin failures++; $display("FAIL rmf_quiet: got %b expected 1", serout8); end
    end
    checks++; if (done_cnt8 - base !== 0)
      begin failures++; $display("FAIL rmf_done_pulses: got %0d expected 0", done_cnt8 - base); end
  endtask

  task automatic test_enable();
    int base;
    sel7 = 1'b0;
    do_reset();
    base = done_cnt8;
    en = 1'b0;
    do_write(9'h77);
    checks++; if (hold_empty8 !== 1'b1) begin failures++; $display("FAIL en_write_ignored: got %b expected 1", hold_empty8); end
    en = 1'b1;
    do_write(9'h5A);
    en = 1'b0;
    repeat (3) step();
    checks++; if (busy8 !== 1'b0 || hold_empty8 !== 1'b0)
      begin failures++; $display("FAIL en_load_frozen: busy=%b hold_empty=%b expected 0 0", busy8, hold_empty8); end
    en = 1'b1;
    step();
    en = 1'b0;
    shift = 1'b1;
    repeat (4) step();
    shift = 1'b0;
    checks++; if (busy8 !== 1'b1 || serout8 !== 1'b0)
      begin failures++; $display("FAIL en_shift_frozen: busy=%b serout=%b expected 1 0", busy8, serout8); end
    en = 1'b1;
    push_frame(9'h5A, 8, 0, 1);
    for (int i = 0; i < 10; i++) tick_once(1'b0, '0, 1'b0, 1'b0);
    checks++; if (done_cnt8 - base !== 1 || busy8 !== 1'b0)
      begin failures++; $display("FAIL en_frame_end: done_pulses=%0d busy=%b expected 1 0", done_cnt8 - base, busy8); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_parity_stop();
    test_back_to_back();
    test_overrun();
    test_write_load();
    test_break();
    test_reset_mid_frame();
    test_enable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serout_shift_param.md
# serout_shift_param

Parametrised serial-output transmitter for the POKEY serial port path, succeeding the fixed 10-bit SEROUT shifter. It adds a double-buffered holding register, a configurable data width, optional parity, one or two stop bits, a break override and status/interrupt flags. It sits between the register-write decode (SEROUT address strobe) and the SIO output pin, and is advanced by the serial clock-tick generator.

## Interface
- DATA_W, 8, data bits per frame (5..9)
- STOP_BITS, 1, stop bits per frame (1 or 2)
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  clock-enable qualifier; no state changes when 0 (reset excepted)
- D  in  DATA_W  write data for the holding register
- wr  in  1  holding-register write strobe (SEROUT address decode)
- shift  in  1  bit-period tick from the serial clock generator
- brk  in  1  force line low (break)
- serout  out  1  serial line, idle high
- hold_empty  out  1  holding register can accept a byte (IRQ source)
- busy  out  1  frame in progress in the shifter
- done  out  1  one-cycle pulse when a frame's last stop bit completes
- overrun  out  1  sticky: a write landed on a full holding register

## Operation
- FRAME = 1 + DATA_W + (PARITY != 0) + STOP_BITS bits, sent in this order: start bit 0, data LSB first, parity, stop bit(s) 1.
- Parity bit: XOR of the data bits for even parity, and its inverse for odd parity.
- Reset (rst_n=0 at an edge): serout=1, hold_empty=1, busy=0, done=0, overrun=0, and bit counter=0. Reset wins over every other input, including mid-frame; the partial frame is discarded.
- Write (en & wr): D is captured into the holding register and hold_empty clears. If hold_empty was already 0, the old byte is overwritten and overrun sets.
- overrun clears only on reset or on a write while hold_empty=1.
- Load (en & !busy & !hold_empty): the holding byte plus the computed parity and stop bits go into the shift register. busy sets, hold_empty sets, the counter is set to FRAME, and serout is driven to the start bit.
- Write and load in the same cycle: load takes the old holding byte, and the new D is stored. hold_empty stays 0 and overrun does not set.
- Shift (en & shift & busy): the next frame bit goes to serout and the counter decrements.
- Completing the frame: the shift that occurs with counter=1 ends the frame. serout returns to idle 1, busy clears and done pulses.
- Shift while !busy is ignored. A load cycle ignores shift.
- Back-to-back frames: if the holding register is full when the frame ends, the load happens on the next en cycle. No idle bit is inserted beyond that one cycle.
- brk=1: serout is forced to 0 combinationally on the output register input (serout=0 on the next edge). Shifting, counting and flags proceed unaffected. When brk falls, serout shows the current frame bit, or 1 if idle.
- Width rule: the counter is clog2(FRAME+1) bits wide. The shift register is FRAME-1 bits, because the start bit is emitted directly at load.

## Timing
- Every output is registered. A qualifying edge at cycle N makes the response visible in cycle N+1.
- Write at N with shifter idle and en held high:
  - hold_empty=0 in N+1.
  - Load happens at edge N+1.
  - serout=0 (start bit), busy=1 and hold_empty=1 in N+2.
- Each further start-bit-relative shift tick at cycle M puts the next bit on serout at M+1.
- The Kth shift tick after load (K = FRAME) returns serout=1 and busy=0, with done=1 for exactly that one cycle.
- The start-bit duration equals the interval from load to the first shift tick. The generator aligns shift ticks so this interval is one bit period.
- en=0 freezes all state including pending loads. Inputs sampled while en=0 are ignored; reset is not.

## Test plan
- Reset mid-frame: DATA_W=8, send 0xA5, assert rst_n=0 after 4 shift ticks -> next cycle serout=1, busy=0, hold_empty=1, overrun=0. No further bits follow.
- Basic frame: DATA_W=8, PARITY=0, STOP_BITS=1, write 0x35 -> serout sequence 0,1,0,1,0,1,1,0,0,1, then idle. done pulses once after tick 10.
- Parity and stop bits: DATA_W=7, PARITY=2, STOP_BITS=2, write 0x41 -> sequence 0,1,0,0,0,0,0,1,1,1,1 (odd-parity bit 1). FRAME=11 ticks.
- Double buffer: write 0x12, then write 0x34 during frame 1 -> frames 0x12 and 0x34 sent back-to-back with no extra bit period. hold_empty rises at the second load and overrun stays 0.
- Overrun: write 0x11, then 0x22 and 0x33 while frame 1 is busy -> overrun=1, and the frames sent are 0x11 and 0x33 only.
- Break and simultaneous events:
  - Write coincident with load -> the old byte is sent and the new byte is queued.
  - brk held for 3 ticks mid-frame -> serout=0 throughout, frame timing is unchanged, and the remaining bits resume correctly.
